// File: rtl/ux607_gnrl_wishb8toicb32_pkg.sv
// ux607_gnrl_wishb8toicb32_pkg: shared width, state type and byte-lane helper for the WB8-to-ICB32 bridge
package ux607_gnrl_wishb8toicb32_pkg;
  localparam int AW = 32;
  typedef enum logic [1:0] {IDLE, CMD, RSP, TERM} state_e;
  function automatic logic [7:0] lane_sel(input logic [31:0] d, input logic [1:0] o);
    return d[{o, 3'b000} +: 8];
  endfunction
endpackage

// File: rtl/ux607_gnrl_wishb8toicb32_if.sv
// ux607_gnrl_wishb8toicb32_if: Wishbone 8-bit slave side plus ICB 32-bit initiator side of the bridge
interface ux607_gnrl_wishb8toicb32_if #(parameter int AW = 32);
  logic [AW-1:0] wb_adr;
  logic [7:0]    wb_dat_w;
  logic [7:0]    wb_dat_r;
  logic          wb_we;
  logic          wb_stb;
  logic          wb_cyc;
  logic          wb_ack;
  logic          wb_err;
  logic          o_icb_cmd_valid;
  logic          o_icb_cmd_ready;
  logic          o_icb_cmd_read;
  logic [AW-1:0] o_icb_cmd_addr;
  logic [31:0]   o_icb_cmd_wdata;
  logic [3:0]    o_icb_cmd_wmask;
  logic [1:0]    o_icb_cmd_size;
  logic          o_icb_rsp_valid;
  logic          o_icb_rsp_ready;
  logic          o_icb_rsp_err;
  logic [31:0]   o_icb_rsp_rdata;
  modport slave (
    input  wb_adr, wb_dat_w, wb_we, wb_stb, wb_cyc,
    output wb_dat_r, wb_ack, wb_err,
    output o_icb_cmd_valid, o_icb_cmd_read, o_icb_cmd_addr, o_icb_cmd_wdata, o_icb_cmd_wmask, o_icb_cmd_size,
    input  o_icb_cmd_ready,
    input  o_icb_rsp_valid, o_icb_rsp_err, o_icb_rsp_rdata,
    output o_icb_rsp_ready
  );
  modport master (
    output wb_adr, wb_dat_w, wb_we, wb_stb, wb_cyc,
    input  wb_dat_r, wb_ack, wb_err,
    input  o_icb_cmd_valid, o_icb_cmd_read, o_icb_cmd_addr, o_icb_cmd_wdata, o_icb_cmd_wmask, o_icb_cmd_size,
    output o_icb_cmd_ready,
    output o_icb_rsp_valid, o_icb_rsp_err, o_icb_rsp_rdata,
    input  o_icb_rsp_ready
  );
endinterface

// File: rtl/ux607_gnrl_wishb8toicb32.sv
// ux607_gnrl_wishb8toicb32: one WB8 access becomes one byte ICB32 transaction, WB terminated after the ICB response
module ux607_gnrl_wishb8toicb32
  import ux607_gnrl_wishb8toicb32_pkg::*;
(
  input logic clk,
  input logic rst_n,
  ux607_gnrl_wishb8toicb32_if.slave bus
);
  state_e        state_q, state_d;
  logic [AW-1:0] adr_q, adr_d;
  logic          we_q, we_d;
  logic [7:0]    dat_q, dat_d;
  logic [7:0]    dat_r_q, dat_r_d;
  logic          abort_q, abort_d;
  logic          ack_q, ack_d;
  logic          werr_q, werr_d;
  logic          take, done;
  always_comb begin
    take    = state_q == IDLE && bus.wb_cyc && bus.wb_stb;
    done    = state_q == RSP && bus.o_icb_rsp_valid;
    state_d = state_q == IDLE ? (take ? CMD : IDLE)
            : state_q == CMD  ? (bus.o_icb_cmd_ready ? RSP : CMD)
            : state_q == RSP  ? (bus.o_icb_rsp_valid ? TERM : RSP)
            : IDLE;
    adr_d   = take ? bus.wb_adr : adr_q;
    we_d    = take ? bus.wb_we : we_q;
    dat_d   = take ? bus.wb_dat_w : dat_q;
    abort_d = state_q == IDLE ? 1'b0 : abort_q | ~bus.wb_cyc;
    ack_d   = done && !bus.o_icb_rsp_err && !abort_d;
    werr_d  = done && bus.o_icb_rsp_err && !abort_d;
    dat_r_d = !done ? dat_r_q : (we_q || bus.o_icb_rsp_err) ? 8'h00 : lane_sel(bus.o_icb_rsp_rdata, adr_q[1:0]);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      adr_q   <= '0;
      we_q    <= 1'b0;
      dat_q   <= 8'h00;
      dat_r_q <= 8'h00;
      abort_q <= 1'b0;
      ack_q   <= 1'b0;
      werr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      adr_q   <= adr_d;
      we_q    <= we_d;
      dat_q   <= dat_d;
      dat_r_q <= dat_r_d;
      abort_q <= abort_d;
      ack_q   <= ack_d;
      werr_q  <= werr_d;
    end
  end
  assign bus.o_icb_cmd_valid = state_q == CMD;
  assign bus.o_icb_cmd_read  = ~we_q;
  assign bus.o_icb_cmd_addr  = adr_q;
  assign bus.o_icb_cmd_wdata = {4{dat_q}};
  assign bus.o_icb_cmd_wmask = we_q ? 4'b0001 << adr_q[1:0] : 4'b0000;
  assign bus.o_icb_cmd_size  = 2'b00;
  assign bus.o_icb_rsp_ready = state_q == RSP;
  assign bus.wb_ack          = ack_q;
  assign bus.wb_err          = werr_q;
  assign bus.wb_dat_r        = dat_r_q;
endmodule

// File: tb/tb_ux607_gnrl_wishb8toicb32.sv
// tb_ux607_gnrl_wishb8toicb32: directed and random WB accesses against an ICB responder and expected-result model
module tb_ux607_gnrl_wishb8toicb32;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_chk = 0;
  int n_fail = 0;
  ux607_gnrl_wishb8toicb32_if bus();
  ux607_gnrl_wishb8toicb32 dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic idle_inputs();
    bus.wb_cyc = 0; bus.wb_stb = 0; bus.wb_we = 0; bus.wb_adr = '0; bus.wb_dat_w = '0;
    bus.o_icb_cmd_ready = 0; bus.o_icb_rsp_valid = 0; bus.o_icb_rsp_err = 0; bus.o_icb_rsp_rdata = $urandom;
  endtask
  task automatic xfer(input logic [31:0] adr, input logic we, input logic [7:0] dat,
                      input logic [31:0] rsp_data, input logic rerr, input int rdly, input int vdly, input int abort_at);
    int n = 0, vcnt = 0, rcnt = 0, acks = 0, lat = -1, end_n = -1;
    bit hs = 0, rdone = 0, hs_pend = 0, r_pend = 0;
    logic [3:0] em;
    logic [7:0] eb;
    em = we ? 4'(1 << adr[1:0]) : 4'h0;
    eb = (we || rerr) ? 8'h00 : 8'((rsp_data >> (8 * adr[1:0])) & 32'hFF);
    @(negedge clk);
    bus.wb_cyc = 1; bus.wb_stb = 1; bus.wb_adr = adr; bus.wb_we = we; bus.wb_dat_w = dat;
    while (n < 80 && (end_n < 0 || n < end_n + 3)) begin
      @(negedge clk);
      n++;
      if (hs_pend) hs = 1;
      if (r_pend) rdone = 1;
      hs_pend = 0; r_pend = 0;
      bus.o_icb_cmd_ready = 0; bus.o_icb_rsp_valid = 0; bus.o_icb_rsp_err = 0; bus.o_icb_rsp_rdata = $urandom;
      if (bus.o_icb_cmd_valid) begin
        chk("cmd_after_hs", hs, 0);
        chk("cmd_addr", bus.o_icb_cmd_addr, adr);
        chk("cmd_read", bus.o_icb_cmd_read, !we);
        chk("cmd_wmask", bus.o_icb_cmd_wmask, em);
        chk("cmd_size", bus.o_icb_cmd_size, 0);
        if (we) chk("cmd_wdata", bus.o_icb_cmd_wdata, {dat, dat, dat, dat});
        vcnt++;
        if (vcnt > rdly) begin bus.o_icb_cmd_ready = 1; hs_pend = 1; end
      end
      if (bus.o_icb_rsp_ready && hs && !rdone) begin
        rcnt++;
        if (rcnt > vdly) begin
          bus.o_icb_rsp_valid = 1; bus.o_icb_rsp_err = rerr; bus.o_icb_rsp_rdata = rsp_data; r_pend = 1;
        end
      end
      if (bus.wb_ack || bus.wb_err) begin
        acks++;
        if (lat < 0) begin
          lat = n; end_n = n;
          chk("wb_ack", bus.wb_ack, !rerr);
          chk("wb_err", bus.wb_err, rerr);
          chk("wb_dat_r", bus.wb_dat_r, eb);
        end
        bus.wb_cyc = 0; bus.wb_stb = 0;
      end
      if (n == abort_at) begin bus.wb_cyc = 0; bus.wb_stb = 0; end
      if (abort_at > 0 && rdone && end_n < 0) end_n = n;
    end
    chk("no_timeout", n < 80, 1);
    chk("cmd_handshake", hs, 1);
    chk("rsp_consumed", rdone, 1);
    chk("term_count", acks, abort_at > 0 ? 0 : 1);
    if (abort_at == 0) chk("latency", lat, 3 + rdly + vdly);
    idle_inputs();
  endtask
  initial begin
    idle_inputs();
    repeat (3) @(negedge clk);
    chk("rst_ack", bus.wb_ack, 0);
    chk("rst_err", bus.wb_err, 0);
    chk("rst_dat_r", bus.wb_dat_r, 0);
    chk("rst_cmd_valid", bus.o_icb_cmd_valid, 0);
    chk("rst_rsp_ready", bus.o_icb_rsp_ready, 0);
    rst_n = 1;
    @(negedge clk);
    bus.wb_cyc = 1;
    @(negedge clk);
    chk("cyc_no_stb", bus.o_icb_cmd_valid, 0);
    bus.wb_cyc = 0;
    xfer(32'h1002, 1, 8'hA5, $urandom, 0, 0, 0, 0);
    xfer(32'h2003, 0, 8'h00, 32'h12345678, 0, 0, 0, 0);
    xfer(32'h2000, 0, 8'h00, 32'h12345678, 0, 0, 0, 0);
    xfer(32'h2001, 0, 8'h00, 32'h12345678, 0, 0, 0, 0);
    xfer(32'h2002, 0, 8'h00, 32'h12345678, 0, 0, 0, 0);
    xfer(32'h3001, 0, 8'h00, 32'hCAFEF00D, 0, 5, 4, 0);
    xfer(32'h4002, 0, 8'h00, 32'hDEADBEEF, 1, 0, 0, 0);
    xfer(32'h5003, 1, 8'h3C, $urandom, 0, 2, 1, 1);
    xfer(32'h5003, 1, 8'h3C, $urandom, 0, 0, 0, 0);
    xfer(32'h6000, 0, 8'h00, 32'h0BADCAFE, 0, 0, 2, 3);
    xfer(32'h6001, 0, 8'h00, 32'h0BADCAFE, 0, 1, 0, 0);
    @(negedge clk);
    bus.wb_cyc = 1; bus.wb_stb = 1; bus.wb_we = 1; bus.wb_adr = 32'h7001; bus.wb_dat_w = 8'h5A;
    for (int i = 0; i < 10 && !bus.o_icb_rsp_ready; i++) begin
      @(negedge clk);
      bus.o_icb_cmd_ready = bus.o_icb_cmd_valid;
    end
    chk("reached_rsp", bus.o_icb_rsp_ready, 1);
    rst_n = 0;
    #1;
    chk("mid_rst_rsp_ready", bus.o_icb_rsp_ready, 0);
    chk("mid_rst_cmd_valid", bus.o_icb_cmd_valid, 0);
    chk("mid_rst_ack", bus.wb_ack, 0);
    chk("mid_rst_err", bus.wb_err, 0);
    chk("mid_rst_dat_r", bus.wb_dat_r, 0);
    chk("mid_rst_addr", bus.o_icb_cmd_addr, 0);
    chk("mid_rst_wdata", bus.o_icb_cmd_wdata, 0);
    idle_inputs();
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk("post_rst_cmd_valid", bus.o_icb_cmd_valid, 0);
    chk("post_rst_rsp_ready", bus.o_icb_rsp_ready, 0);
    xfer(32'h7001, 1, 8'h5A, $urandom, 0, 0, 0, 0);
    for (int i = 0; i < 24; i++) begin
      logic [31:0] a, d;
      a = $urandom; d = $urandom;
      xfer(a, 1'($urandom_range(0, 1)), 8'($urandom), d, $urandom_range(0, 7) == 0,
           $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 5) == 0 ? 1 : 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
